// File: rtl/timer_ctrl_pkg.sv
// Shared op codes, timer register map, control-bit positions and sequencer states
// for the timer command sequencer.
package timer_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP           = 3'd0,
        OP_START         = 3'd1,
        OP_STOP          = 3'd2,
        OP_CLEAR         = 3'd3,
        OP_SET_PERIOD    = 3'd4,
        OP_START_ONESHOT = 3'd5,
        OP_RESTART       = 3'd6,
        OP_NOP7          = 3'd7
    } op_e;

    localparam logic [1:0] TMR_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_ADDR_PERIOD = 2'd1;
    localparam logic [1:0] TMR_ADDR_VALUE  = 2'd2;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_CTRL,
        S_W_CLR,
        S_W_PER,
        S_W_RESTORE
    } state_e;

    function automatic logic [31:0] ctrl_word(input logic en, input logic clr);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]  = en;
        w[CTRL_CLR_BIT] = clr;
        return w;
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Command handshake plus timer register bus between the sequencer and its neighbours.
// slave = the sequencer; master = the command source together with the timer side.
interface timer_ctrl_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        tmr_we;
    logic [1:0]  tmr_addr;
    logic [31:0] tmr_din;
    logic [31:0] tmr_val;

    modport master (
        output cmd_valid, cmd_op, cmd_data, tmr_val,
        input  cmd_ready, tmr_we, tmr_addr, tmr_din
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, tmr_val,
        output cmd_ready, tmr_we, tmr_addr, tmr_din
    );

endinterface

// File: rtl/timer_ctrl.sv
// Timer command sequencer: ops -> timer register writes, shadow ctrl/period, wrap irq, one-shot stop.
// Optional saturating wrap counter when TIMER_CTRL_WRAP_CNT_EN is defined.
//
// state     | meaning
// S_IDLE    | accepting ops; may issue the one-shot auto-stop write
// S_W_CTRL  | write ctrl for START / STOP / START_ONESHOT
// S_W_CLR   | write ctrl=clear for CLEAR / RESTART
// S_W_PER   | write period for SET_PERIOD / RESTART
// S_W_RESTORE | write ctrl back to run state after a clear
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter logic [31:0] PERIOD_RST = 32'hFFFF_FFFF,
    parameter int          WRAP_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    timer_ctrl_if.slave  bus,
    output logic         busy,
    output logic         irq,
    input  logic         irq_ack
`ifdef TIMER_CTRL_WRAP_CNT_EN
    ,
    output logic [WRAP_W-1:0] wrap_cnt
`endif
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] per_q, per_d;
    logic        oneshot_q, oneshot_d;
    logic        stop_pend_q, stop_pend_d;
    logic        run_q, run_d;
    logic        irq_q, irq_d;

    logic        wrap, idle, auto_stop;
    logic        tmr_we_c;
    logic [1:0]  tmr_addr_c;
    logic [31:0] tmr_din_c;

    assign wrap      = ctrl_q[CTRL_EN_BIT] & ~ctrl_q[CTRL_CLR_BIT] & (bus.tmr_val >= per_q);
    assign idle      = (state_q == S_IDLE);
    assign auto_stop = idle & oneshot_q & (wrap | stop_pend_q);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        ctrl_d     = ctrl_q;
        per_d      = per_q;
        oneshot_d  = oneshot_q;
        run_d      = run_q;
        tmr_we_c   = 1'b0;
        tmr_addr_c = '0;
        tmr_din_c  = '0;
        case (state_q)
            S_IDLE: begin
                if (auto_stop) begin
                    tmr_we_c   = 1'b1;
                    tmr_addr_c = TMR_ADDR_CTRL;
                    tmr_din_c  = ctrl_word(1'b0, 1'b0);
                    ctrl_d     = 2'b00;
                    oneshot_d  = 1'b0;
                end else if (bus.cmd_valid) begin
                    op_d   = op_e'(bus.cmd_op);
                    data_d = bus.cmd_data;
                    case (op_e'(bus.cmd_op))
                        OP_START, OP_STOP, OP_START_ONESHOT: state_d = S_W_CTRL;
                        OP_SET_PERIOD:                       state_d = S_W_PER;
                        OP_CLEAR, OP_RESTART:                state_d = S_W_CLR;
                        default:                             state_d = S_IDLE;
                    endcase
                end
            end
            S_W_CTRL: begin
                tmr_we_c   = 1'b1;
                tmr_addr_c = TMR_ADDR_CTRL;
                tmr_din_c  = ctrl_word(op_q != OP_STOP, 1'b0);
                ctrl_d     = tmr_din_c[1:0];
                oneshot_d  = (op_q == OP_START_ONESHOT);
                state_d    = S_IDLE;
            end
            S_W_CLR: begin
                tmr_we_c   = 1'b1;
                tmr_addr_c = TMR_ADDR_CTRL;
                tmr_din_c  = ctrl_word(1'b0, 1'b1);
                ctrl_d     = tmr_din_c[1:0];
                // the run bit is lost once clear is written, so keep it for the restore
                run_d      = ctrl_q[CTRL_EN_BIT];
                state_d    = (op_q == OP_RESTART) ? S_W_PER : S_W_RESTORE;
            end
            S_W_PER: begin
                tmr_we_c   = 1'b1;
                tmr_addr_c = TMR_ADDR_PERIOD;
                tmr_din_c  = data_q;
                per_d      = data_q;
                state_d    = (op_q == OP_RESTART) ? S_W_RESTORE : S_IDLE;
            end
            S_W_RESTORE: begin
                tmr_we_c   = 1'b1;
                tmr_addr_c = TMR_ADDR_CTRL;
                tmr_din_c  = ctrl_word((op_q == OP_RESTART) | run_q, 1'b0);
                ctrl_d     = tmr_din_c[1:0];
                if (op_q == OP_RESTART) oneshot_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        stop_pend_d = stop_pend_q | (~idle & oneshot_q & wrap);
        if (!oneshot_d) stop_pend_d = 1'b0;

        irq_d = wrap ? 1'b1 : (irq_ack ? 1'b0 : irq_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            data_q      <= '0;
            ctrl_q      <= '0;
            per_q       <= PERIOD_RST;
            oneshot_q   <= 1'b0;
            stop_pend_q <= 1'b0;
            run_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            per_q       <= per_d;
            oneshot_q   <= oneshot_d;
            stop_pend_q <= stop_pend_d;
            run_q       <= run_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.cmd_ready = idle & ~auto_stop;
    assign bus.tmr_we    = tmr_we_c;
    assign bus.tmr_addr  = tmr_addr_c;
    assign bus.tmr_din   = tmr_din_c;
    assign busy          = ~idle;
    assign irq           = irq_q;

`ifdef TIMER_CTRL_WRAP_CNT_EN
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (state_q == S_W_CLR)
            wrap_cnt_d = '0;
        else if (wrap && !(&wrap_cnt_q))
            wrap_cnt_d = wrap_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) wrap_cnt_q <= '0;
        else     wrap_cnt_q <= wrap_cnt_d;
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

endmodule
